// File: rtl/dcache_pkg.sv
// Shared types and field positions for the data-cache controller.
package dcache_pkg;

    localparam int TAG_W         = 23;
    localparam int INDEX_W       = 4;
    localparam int OFFSET_W      = 5;
    localparam int WORD_SEL_W    = 3;
    localparam int WORD_W        = 32;
    localparam int LINE_BITS     = 256;
    localparam int SRAM_TAG_W    = 25;
    localparam int TAG_VALID_BIT = 24;
    localparam int TAG_DIRTY_BIT = 23;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MISS,
        ST_WRITEBACK,
        ST_REFILL,
        ST_REPLAY
    } state_t;

    function automatic logic [SRAM_TAG_W-1:0] make_tag(input logic valid,
                                                        input logic dirty,
                                                        input logic [TAG_W-1:0] tag);
        return {valid, dirty, tag};
    endfunction

endpackage

// File: rtl/dcache_word_merge.sv
// Extracts one 32-bit word from a cache line and builds a copy of the line
// with that word replaced.
module dcache_word_merge
    import dcache_pkg::*;
(
    input  logic [LINE_BITS-1:0]  line_i,
    input  logic [WORD_SEL_W-1:0] word_sel_i,
    input  logic [WORD_W-1:0]     word_i,
    output logic [LINE_BITS-1:0]  line_o,
    output logic [WORD_W-1:0]     word_o
);

    always_comb begin
        line_o = line_i;
        line_o[word_sel_i*WORD_W +: WORD_W] = word_i;
    end

    assign word_o = line_i[word_sel_i*WORD_W +: WORD_W];

endmodule

// File: rtl/dcache_controller.sv
// Data-cache control stage: hit path to the 2-way SRAM, write-back of a dirty
// victim and line refill from memory on a miss, then replay of the access.
//   state     | meaning
//   IDLE      | serve hits, detect miss
//   MISS      | capture victim, pick writeback or refill
//   WRITEBACK | dirty victim going out, wait for ack
//   REFILL    | line coming in, written to SRAM on ack
//   REPLAY    | one bubble before the access re-looks-up
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int MEM_ADDR_W = 32,
    parameter int LINE_W     = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [MEM_ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]           cpu_data_i,
    output logic [31:0]           cpu_data_o,
    output logic                  cpu_stall_o,

    output logic [INDEX_W-1:0]    sram_addr_o,
    output logic [SRAM_TAG_W-1:0] sram_tag_o,
    output logic [LINE_W-1:0]     sram_data_o,
    output logic                  sram_enable_o,
    output logic                  sram_write_o,
    input  logic [SRAM_TAG_W-1:0] sram_tag_i,
    input  logic [LINE_W-1:0]     sram_data_i,
    input  logic                  sram_hit_i,

    output logic [MEM_ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0]     mem_data_o,
    output logic                  mem_enable_o,
    output logic                  mem_write_o,
    input  logic [LINE_W-1:0]     mem_data_i,
    input  logic                  mem_ack_i
);

    state_t                  state;
    logic [TAG_W-1:0]        req_tag;
    logic [INDEX_W-1:0]      req_index;
    logic [WORD_SEL_W-1:0]   req_word;
    logic [INDEX_W-1:0]      miss_index;
    logic                    victim_dirty;
    logic [LINE_W-1:0]       store_line;
    logic [31:0]             load_word;
    logic [1:0]              unused_byte_offset;

    assign req_tag            = cpu_addr_i[OFFSET_W+INDEX_W +: TAG_W];
    assign req_index          = cpu_addr_i[OFFSET_W +: INDEX_W];
    assign req_word           = cpu_addr_i[2 +: WORD_SEL_W];
    assign unused_byte_offset = cpu_addr_i[1:0];
    assign victim_dirty       = sram_tag_i[TAG_VALID_BIT] & sram_tag_i[TAG_DIRTY_BIT];

    dcache_word_merge u_word_merge (
        .line_i     (sram_data_i),
        .word_sel_i (req_word),
        .word_i     (cpu_data_i),
        .line_o     (store_line),
        .word_o     (load_word)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            miss_index   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_req_i && !sram_hit_i)
                        state <= ST_MISS;
                end
                ST_MISS: begin
                    miss_index   <= req_index;
                    mem_enable_o <= 1'b1;
                    mem_data_o   <= sram_data_i;
                    if (victim_dirty) begin
                        mem_addr_o  <= {sram_tag_i[TAG_W-1:0], req_index, {OFFSET_W{1'b0}}};
                        mem_write_o <= 1'b1;
                        state       <= ST_WRITEBACK;
                    end else begin
                        mem_addr_o  <= {req_tag, req_index, {OFFSET_W{1'b0}}};
                        mem_write_o <= 1'b0;
                        state       <= ST_REFILL;
                    end
                end
                ST_WRITEBACK: begin
                    // enable stays high: the refill request follows back-to-back
                    if (mem_ack_i) begin
                        mem_addr_o  <= {req_tag, miss_index, {OFFSET_W{1'b0}}};
                        mem_write_o <= 1'b0;
                        state       <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (mem_ack_i) begin
                        mem_enable_o <= 1'b0;
                        state        <= ST_REPLAY;
                    end
                end
                ST_REPLAY: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        sram_addr_o   = req_index;
        sram_tag_o    = make_tag(1'b1, 1'b0, req_tag);
        sram_data_o   = store_line;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        cpu_data_o    = load_word;
        case (state)
            ST_IDLE: begin
                sram_enable_o = cpu_req_i;
                if (cpu_req_i && sram_hit_i && cpu_we_i) begin
                    sram_write_o = 1'b1;
                    sram_tag_o   = make_tag(1'b1, 1'b1, req_tag);
                end
            end
            // keep the lookup alive so the victim is presented for capture
            ST_MISS: sram_enable_o = 1'b1;
            ST_REFILL: begin
                if (mem_ack_i) begin
                    sram_enable_o = 1'b1;
                    sram_write_o  = 1'b1;
                    sram_data_o   = mem_data_i;
                    sram_tag_o    = make_tag(1'b1, 1'b0, req_tag);
                end
            end
            default: ;
        endcase
    end

    assign cpu_stall_o = (state != ST_IDLE) | (cpu_req_i & ~sram_hit_i);

endmodule
